// File: rtl/apb_i2c_regfile.sv
// APB slave register file for an I2C controller core.
// Holds prescale/address/command registers, a transmit data latch and a level-set,
// write-one-to-clear interrupt status with enable mask. Transfers may be stretched by a
// fixed number of PREADY-low wait cycles; all side effects happen only on completion.
module apb_i2c_regfile #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              i_pclk,
  input  logic              i_preset,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  input  logic [DATA_W-1:0] i_status_reg,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic [3:0]        i_irq_src,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_push,
  output logic              o_rx_pop,
  output logic [DATA_W-1:0] o_prescale_reg,
  output logic [DATA_W-1:0] o_address_reg,
  output logic [DATA_W-1:0] o_command_reg,
  output logic              o_irq
);

  // Word offsets (byte address bits [4:2])
  localparam logic [2:0] OffPrescale = 3'd0;
  localparam logic [2:0] OffAddr     = 3'd1;
  localparam logic [2:0] OffStatus   = 3'd2;
  localparam logic [2:0] OffTxData   = 3'd3;
  localparam logic [2:0] OffRxData   = 3'd4;
  localparam logic [2:0] OffCmd      = 3'd5;
  localparam logic [2:0] OffIrqEn    = 3'd6;
  localparam logic [2:0] OffIrqStat  = 3'd7;

  localparam logic [2:0] WaitCnt = 3'(WAIT_STATES);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e            r_state;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_prescale;
  logic [DATA_W-1:0] r_address;
  logic [DATA_W-1:0] r_command;
  logic [DATA_W-1:0] r_tx_data;
  logic [3:0]        r_irq_en;
  logic [3:0]        r_irq_stat;
  logic              r_irq;

  logic              w_hi_zero;
  logic              w_mapped;
  logic [2:0]        w_off;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;
  logic              w_done;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [3:0]        w_w1c;

  // Address bits above the 32-byte window must be zero to hit the map
  if (ADDR_W > 5) begin : g_hi
    assign w_hi_zero = (i_paddr[ADDR_W-1:5] == '0);
  end else begin : g_no_hi
    assign w_hi_zero = 1'b1;
  end

  assign w_off    = i_paddr[4:2];
  assign w_mapped = w_hi_zero && (i_paddr[1:0] == 2'b00);

  // Reset overrides any in-flight access, so completion is suppressed while it is held
  assign o_pready = ~i_preset & i_psel & i_penable & (r_cnt == WaitCnt);
  assign w_done   = o_pready;
  assign w_wr_ok  = w_done & ~w_err & i_pwrite;
  assign w_rd_ok  = w_done & ~w_err & ~i_pwrite;

  // Decode the current-cycle address into an error flag and read value
  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    if (!w_mapped) begin
      w_err = 1'b1;
    end else begin
      case (w_off)
        OffPrescale: w_rdata = r_prescale;
        OffAddr:     w_rdata = r_address;
        OffStatus: begin
          w_err   = i_pwrite;
          w_rdata = i_status_reg;
        end
        OffTxData:   w_err = ~i_pwrite | i_status_reg[DATA_W-1];
        OffRxData: begin
          w_err   = i_pwrite | i_status_reg[DATA_W-2];
          w_rdata = i_rx_data;
        end
        OffCmd:      w_rdata = r_command;
        OffIrqEn:    w_rdata = {{(DATA_W-4){1'b0}}, r_irq_en};
        OffIrqStat:  w_rdata = {{(DATA_W-4){1'b0}}, r_irq_stat};
        default:     w_err = 1'b1;
      endcase
    end
  end

  assign o_prdata  = w_rd_ok ? w_rdata : '0;
  assign o_pslverr = w_done & w_err;
  assign o_tx_push = w_wr_ok & (w_off == OffTxData);
  assign o_rx_pop  = w_rd_ok & (w_off == OffRxData);

  assign w_w1c = (w_wr_ok && (w_off == OffIrqStat)) ? i_pwdata[3:0] : 4'b0000;

  // Transfer FSM and wait counter; the counter runs on every stalled access-phase cycle
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        StIdle:   if (i_psel && i_penable) r_state <= StAccess;
        StAccess: if (o_pready || !i_psel) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
      if (i_psel && i_penable && !o_pready) begin
        r_cnt <= r_cnt + 3'd1;
      end else begin
        r_cnt <= 3'd0;
      end
    end
  end

  // Register writes on successful completion; interrupt set beats same-cycle clear
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_prescale <= '0;
      r_address  <= '0;
      r_command  <= '0;
      r_tx_data  <= '0;
      r_irq_en   <= 4'b0000;
      r_irq_stat <= 4'b0000;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        case (w_off)
          OffPrescale: r_prescale <= i_pwdata;
          OffAddr:     r_address  <= i_pwdata;
          OffTxData:   r_tx_data  <= i_pwdata;
          OffCmd:      r_command  <= i_pwdata;
          OffIrqEn:    r_irq_en   <= i_pwdata[3:0];
          default:     ;
        endcase
      end
      r_irq_stat <= (r_irq_stat & ~w_w1c) | i_irq_src;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  assign o_tx_data      = r_tx_data;
  assign o_prescale_reg = r_prescale;
  assign o_address_reg  = r_address;
  assign o_command_reg  = r_command;
  assign o_irq          = r_irq;

endmodule

// File: tb/tb_apb_i2c_regfile.sv
// Directed bench for apb_i2c_regfile with two wait states per transfer.
module tb_apb_i2c_regfile;

  logic       clk;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] status;
  logic [7:0] rx_data;
  logic [3:0] irq_src;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       rx_pop;
  logic [7:0] prescale;
  logic [7:0] address;
  logic [7:0] command;
  logic       irq;

  int total = 0;
  int bad   = 0;

  apb_i2c_regfile #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .WAIT_STATES(2)
  ) dut (
    .i_pclk        (clk),
    .i_preset      (preset),
    .i_psel        (psel),
    .i_penable     (penable),
    .i_pwrite      (pwrite),
    .i_paddr       (paddr),
    .i_pwdata      (pwdata),
    .o_prdata      (prdata),
    .o_pready      (pready),
    .o_pslverr     (pslverr),
    .i_status_reg  (status),
    .i_rx_data     (rx_data),
    .i_irq_src     (irq_src),
    .o_tx_data     (tx_data),
    .o_tx_push     (tx_push),
    .o_rx_pop      (rx_pop),
    .o_prescale_reg(prescale),
    .o_address_reg (address),
    .o_command_reg (command),
    .o_irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; counts PREADY-low cycles and strobes seen during the access phase
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic err, output int lows,
                     output int pushes, output int pops);
    logic seen;
    seen = 1'b0; lows = 0; pushes = 0; pops = 0; rd = '0; err = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      pushes += int'(tx_push);
      pops   += int'(rx_pop);
      if (pready) begin
        seen = 1'b1;
        rd   = prdata;
        err  = pslverr;
      end else begin
        lows++;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("pready_seen", 32'(seen), 32'h1);
  endtask

  task automatic pulse_src(input logic [3:0] v);
    @(posedge clk); #1 irq_src = v;
    @(posedge clk); #1 irq_src = 4'b0000;
  endtask

  logic [7:0] rd;
  logic       err;
  int         lows;
  int         pushes;
  int         pops;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status = '0; rx_data = '0; irq_src = '0;
    repeat (2) @(posedge clk);
    #1 preset = 1'b0;
    @(negedge clk);
    chk("rst_prdata", 32'(prdata), 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_prescale", 32'(prescale), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Two wait states then completion
    apb(1'b1, 8'h00, 8'h5A, rd, err, lows, pushes, pops);
    chk("ws_lows", 32'(lows), 32'd2);
    chk("ws_err", 32'(err), 32'h0);
    chk("ws_prescale", 32'(prescale), 32'h5A);
    apb(1'b0, 8'h00, 8'h00, rd, err, lows, pushes, pops);
    chk("rd_prescale", 32'(rd), 32'h5A);
    apb(1'b1, 8'h04, 8'h11, rd, err, lows, pushes, pops);
    chk("addr_reg", 32'(address), 32'h11);
    apb(1'b1, 8'h14, 8'hC3, rd, err, lows, pushes, pops);
    chk("cmd_reg", 32'(command), 32'hC3);
    apb(1'b0, 8'h14, 8'h00, rd, err, lows, pushes, pops);
    chk("rd_cmd", 32'(rd), 32'hC3);

    // TXDATA with and without tx_full
    apb(1'b1, 8'h0C, 8'h3C, rd, err, lows, pushes, pops);
    chk("tx_push_cnt", 32'(pushes), 32'd1);
    chk("tx_err", 32'(err), 32'h0);
    chk("tx_data", 32'(tx_data), 32'h3C);
    status = 8'h80;
    apb(1'b1, 8'h0C, 8'h55, rd, err, lows, pushes, pops);
    chk("txfull_err", 32'(err), 32'h1);
    chk("txfull_push", 32'(pushes), 32'd0);
    chk("txfull_data", 32'(tx_data), 32'h3C);
    status = 8'h00;
    apb(1'b0, 8'h0C, 8'h00, rd, err, lows, pushes, pops);
    chk("txrd_err", 32'(err), 32'h1);
    chk("txrd_rdata", 32'(rd), 32'h0);

    // RXDATA with and without rx_empty
    rx_data = 8'hA7;
    apb(1'b0, 8'h10, 8'h00, rd, err, lows, pushes, pops);
    chk("rx_rdata", 32'(rd), 32'hA7);
    chk("rx_pop_cnt", 32'(pops), 32'd1);
    chk("rx_err", 32'(err), 32'h0);
    status = 8'h40;
    apb(1'b0, 8'h10, 8'h00, rd, err, lows, pushes, pops);
    chk("rxempty_err", 32'(err), 32'h1);
    chk("rxempty_rdata", 32'(rd), 32'h0);
    chk("rxempty_pop", 32'(pops), 32'd0);
    status = 8'h25;
    apb(1'b0, 8'h08, 8'h00, rd, err, lows, pushes, pops);
    chk("status_rd", 32'(rd), 32'h25);
    status = 8'h00;

    // Illegal accesses: no side effects
    apb(1'b1, 8'h08, 8'hFF, rd, err, lows, pushes, pops);
    chk("wr_status_err", 32'(err), 32'h1);
    apb(1'b1, 8'h20, 8'h77, rd, err, lows, pushes, pops);
    chk("unmap20_err", 32'(err), 32'h1);
    chk("unmap20_keep", 32'(prescale), 32'h5A);
    apb(1'b1, 8'h02, 8'h99, rd, err, lows, pushes, pops);
    chk("unaligned_err", 32'(err), 32'h1);
    chk("unaligned_keep", 32'(prescale), 32'h5A);
    apb(1'b0, 8'h02, 8'h00, rd, err, lows, pushes, pops);
    chk("unaligned_rd", 32'(rd), 32'h0);
    apb(1'b1, 8'h10, 8'h12, rd, err, lows, pushes, pops);
    chk("wr_rx_err", 32'(err), 32'h1);
    chk("wr_rx_pop", 32'(pops), 32'd0);

    // Interrupts
    apb(1'b1, 8'h18, 8'h01, rd, err, lows, pushes, pops);
    apb(1'b0, 8'h18, 8'h00, rd, err, lows, pushes, pops);
    chk("irq_en_rd", 32'(rd), 32'h1);
    apb(1'b0, 8'h1C, 8'h00, rd, err, lows, pushes, pops);
    chk("irq_stat_idle", 32'(rd), 32'h0);
    pulse_src(4'b0001);
    chk("irq_lag", 32'(irq), 32'h0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'h1);
    apb(1'b0, 8'h1C, 8'h00, rd, err, lows, pushes, pops);
    chk("irq_stat_set", 32'(rd), 32'h1);
    irq_src = 4'b0001;
    apb(1'b1, 8'h1C, 8'h01, rd, err, lows, pushes, pops);
    apb(1'b0, 8'h1C, 8'h00, rd, err, lows, pushes, pops);
    chk("set_beats_clr", 32'(rd), 32'h1);
    irq_src = 4'b0000;
    apb(1'b1, 8'h1C, 8'h01, rd, err, lows, pushes, pops);
    apb(1'b0, 8'h1C, 8'h00, rd, err, lows, pushes, pops);
    chk("w1c_clear", 32'(rd), 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);
    pulse_src(4'b0100);
    repeat (2) @(posedge clk);
    #1 chk("irq_masked", 32'(irq), 32'h0);
    apb(1'b0, 8'h1C, 8'h00, rd, err, lows, pushes, pops);
    chk("irq_stat_b2", 32'(rd), 32'h4);
    pulse_src(4'b0001);
    @(posedge clk); #1;
    chk("irq_again", 32'(irq), 32'h1);

    // Abort by dropping PSEL mid-wait
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h33;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("abort_wait", 32'(pready), 32'h0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk("abort_no_ready", 32'(pready), 32'h0);
    @(posedge clk); #1;
    chk("abort_keep", 32'(prescale), 32'h5A);
    apb(1'b1, 8'h00, 8'h66, rd, err, lows, pushes, pops);
    chk("post_abort_lows", 32'(lows), 32'd2);
    chk("post_abort_val", 32'(prescale), 32'h66);

    // Reset during a wait state
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 8'hEE;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("rstw_wait", 32'(pready), 32'h0);
    @(posedge clk); #1 preset = 1'b1;
    @(negedge clk);
    chk("rstw_push", 32'(tx_push), 32'h0);
    @(posedge clk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk("rstw_prescale", 32'(prescale), 32'h0);
    chk("rstw_cmd", 32'(command), 32'h0);
    chk("rstw_addr", 32'(address), 32'h0);
    chk("rstw_tx_data", 32'(tx_data), 32'h0);
    chk("rstw_irq", 32'(irq), 32'h0);
    chk("rstw_prdata", 32'(prdata), 32'h0);
    chk("rstw_pslverr", 32'(pslverr), 32'h0);
    apb(1'b1, 8'h00, 8'h12, rd, err, lows, pushes, pops);
    chk("rstw_next_lows", 32'(lows), 32'd2);
    chk("rstw_next_err", 32'(err), 32'h0);
    chk("rstw_next_val", 32'(prescale), 32'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_i2c_regfile.md
APB_I2C_REGFILE -- requirements
Module: apb_i2c_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 8, SHALL set the register and data width; legal range 8..32.
REQ-003 Parameter ADDR_W, default 8, SHALL set the APB address width; minimum 5.
REQ-004 Parameter WAIT_STATES, default 0, SHALL set the number of PREADY-low access cycles; legal range 0..7.
REQ-005 PCLK  in  1  clock; all state changes occur on the rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 PSELx, PENABLE, PWRITE  in  1 each  APB select, enable and direction (1 = write).
REQ-008 PADDR  in  ADDR_W  byte address; PWDATA  in  DATA_W  write data.
REQ-009 PRDATA  out  DATA_W; PREADY  out  1; PSLVERR  out  1.
REQ-010 status_reg  in  DATA_W  core status; bit DATA_W-1 = tx_full, bit DATA_W-2 = rx_empty.
REQ-011 rx_data  in  DATA_W  head of the receive FIFO; irq_src  in  4  level interrupt sources.
REQ-012 tx_data  out  DATA_W; tx_push  out  1; rx_pop  out  1  FIFO strobes, one PCLK wide.
REQ-013 prescale_reg, address_reg, command_reg  out  DATA_W; irq  out  1.

Function
REQ-014 Register map, byte offsets: 0x00 PRESCALE RW, 0x04 ADDR RW, 0x08 STATUS RO, 0x0C TXDATA WO, 0x10 RXDATA RO, 0x14 CMD RW, 0x18 IRQ_EN RW (bits 3:0), 0x1C IRQ_STAT W1C (bits 3:0).
REQ-015 Decode SHALL use the current-cycle PADDR, with no registered address; PADDR[1:0] != 0 or PADDR[ADDR_W-1:5] != 0 SHALL be unmapped.
REQ-016 FSM SHALL have states IDLE and ACCESS; IDLE->ACCESS when PSELx&PENABLE; ACCESS->IDLE when PREADY=1 or PSELx=0.
REQ-017 Wait counter SHALL be 3 bits, cleared in IDLE and incremented each ACCESS cycle with PREADY=0.
REQ-018 PREADY SHALL be combinational: PSELx & PENABLE & (cnt == WAIT_STATES); WAIT_STATES=0 gives zero-wait transfers.
REQ-019 Register updates, strobes, PRDATA and PSLVERR SHALL take effect only in the completion cycle (PREADY=1); otherwise PRDATA=0 and PSLVERR=0.
REQ-020 PSLVERR=1 at completion SHALL apply to: unmapped address; write to STATUS or RXDATA; read of TXDATA; TXDATA write with tx_full=1; RXDATA read with rx_empty=1.
REQ-021 An errored access SHALL have no side effects: no register change, no tx_push or rx_pop, and PRDATA=0.
REQ-022 TXDATA write SHALL load tx_data from PWDATA and pulse tx_push for the completion cycle.
REQ-023 RXDATA read SHALL return rx_data on PRDATA and pulse rx_pop in the same cycle.
REQ-024 STATUS read SHALL return status_reg; RW registers SHALL read back their stored value, zero-extended to DATA_W.
REQ-025 IRQ_STAT[i] SHALL set on any cycle with irq_src[i]=1 and clear on a write of 1 to bit i.
REQ-026 When an IRQ_STAT set and clear occur in the same cycle, the set SHALL win.
REQ-027 irq SHALL be registered and equal to |(IRQ_STAT & IRQ_EN) from the previous cycle.
REQ-028 PSELx falling mid-wait SHALL abort the transfer: counter cleared, no side effects.

Reset
REQ-029 While PRESET=1 at a PCLK edge, all stored registers, IRQ_STAT, IRQ_EN, tx_data, the counter, irq and the FSM (to IDLE) SHALL clear to 0.
REQ-030 During reset, tx_push and rx_pop SHALL be 0; reset SHALL take priority over an in-flight access, which SHALL be dropped.

Verification
REQ-031 WAIT_STATES=2, write 0x5A to 0x00 -> PREADY low 2 access cycles then high 1; prescale_reg=0x5A after that edge.
REQ-032 Write 0x3C to 0x0C with tx_full=0 -> tx_push pulses once and tx_data=0x3C; repeat with tx_full=1 -> PSLVERR=1, no pulse, tx_data stays 0x3C.
REQ-033 Read 0x10 with rx_data=0xA7 and rx_empty=0 -> PRDATA=0xA7 and rx_pop pulses once; with rx_empty=1 -> PSLVERR=1, PRDATA=0, no pop.
REQ-034 Accesses to 0x20, 0x02 and a write to 0x08 -> each completes with PSLVERR=1 and no register change.
REQ-035 IRQ_EN=0x1, pulse irq_src[0] -> IRQ_STAT=0x1 and irq=1 one cycle later; W1C 0x1 with irq_src[0] held high -> bit stays 1.
REQ-036 Assert PRESET during a wait state -> next cycle all outputs are 0 and the following transfer completes normally.
